ball_collision_det: RTL
=======================

Name: ball_collision_det

Overview:
- Consumes the ball position from the x/y motion generators and both paddle positions; produces the `collision_det` level that the x motion generator samples on its move tick.
- Holds `collision_det` until the ball has actually moved, so a slow mover cannot miss the event.
- Also detects wall misses and keeps per-player scores for the scoreboard overlay.

Parameters:
- BALL_R, 10, ball half-size in pixels
- PAD_W, 10, paddle width in pixels
- PAD_H, 80, paddle height in pixels
- LEFT_PAD_X, 40, leftmost column of left paddle
- RIGHT_PAD_X, 974, leftmost column of right paddle
- SCREEN_W, 1024, playfield width; right wall at SCREEN_W-1
- SCORE_MAX, 9, score saturation value

Ports:
- pclk  in  1  pixel clock; only clock
- reset  in  1  synchronous, active-low reset
- x_pos  in  12  ball centre column
- y_pos  in  12  ball centre row
- pad_l_y  in  12  left paddle top row
- pad_r_y  in  12  right paddle top row
- collision_det  out  1  paddle-contact level to x motion generator
- hit_side  out  1  side of current/last hit: 0 left, 1 right
- miss_l  out  1  one-cycle pulse, ball touched left wall
- miss_r  out  1  one-cycle pulse, ball touched right wall
- score_l  out  4  left player score
- score_r  out  4  right player score

Behaviour:
- Interface: one clock `pclk`; reset is synchronous and active-low on port `reset`. On `reset`=0 at a `pclk` edge:
  - all outputs go to 0;
  - FSM goes to IDLE;
  - input/compare registers clear.
- Reset mid-HIT drops `collision_det` on the next edge.
- Pipeline:
  - stage 1 registers x_pos, y_pos, pad_l_y, pad_r_y;
  - stage 2 registers the compare flags hit_l, hit_r, wall_l, wall_r.
  - Latency from input change to flag is 2 cycles; FSM outputs follow 1 cycle later.
- Arithmetic is 13-bit unsigned with zero-extension; subtractions never wrap.
- y-overlap for paddle P holds when y_pos+BALL_R >= pad_P_y AND y_pos <= pad_P_y+PAD_H-1+BALL_R.
- hit_l: y-overlap(left) AND LEFT_PAD_X+BALL_R <= x_pos <= LEFT_PAD_X+PAD_W-1+BALL_R.
- hit_r: y-overlap(right) AND RIGHT_PAD_X-BALL_R <= x_pos <= RIGHT_PAD_X+PAD_W-1-BALL_R.
- wall_l: x_pos == BALL_R. wall_r: x_pos+BALL_R == SCREEN_W-1.
- FSM states IDLE, HIT, RELEASE:
  - IDLE: `collision_det`=0. If hit_l or hit_r, go to HIT and latch x_hit = registered x_pos. Set `hit_side` = 0 if hit_l, else 1. If both are set, left has priority.
  - HIT: `collision_det`=1. Stay until registered x_pos != x_hit, i.e. the mover has consumed the event, then go to RELEASE. There is no timeout.
  - RELEASE: `collision_det`=0. Go to IDLE on the first cycle the latched side's hit flag is 0. This blocks re-trigger while the ball is still inside the paddle zone.
- `hit_side` holds its value until the next IDLE->HIT transition.
- Miss pulses are rising-edge detected on wall_l/wall_r: exactly one pulse per wall contact, however long the ball sits at the wall.
- Each miss_l pulse increments score_r; each miss_r pulse increments score_l.
- Scores saturate at SCORE_MAX; a further miss leaves the score unchanged and still pulses.
- Wall events are independent of the FSM; a wall touch and a paddle hit may occur in the same cycle and are both honoured.

Optional Feature:
- Macro BALL_COLLISION_SCORE_EN.
- Defined: wall detection, miss pulses and score counters are present as above.
- Undefined: that logic is not compiled; miss_l, miss_r, score_l and score_r are tied to 0, and paddle collision behaviour is unchanged.

Test Plan:
- Reset: reset=0 for 3 cycles with x_pos=55, y_pos=320, pad_l_y=300 -> collision_det=0, scores 0. Release reset -> collision_det=1 and hit_side=0 three cycles later.
- HIT hold: after the previous case, hold x_pos=55 for 1000 cycles -> collision_det stays 1. Step x_pos to 56 -> collision_det=0 within 3 cycles. Hold x_pos=56 (still in zone) -> no re-assert. Move x_pos to 80 then 55 -> asserts again.
- Right paddle: pad_r_y=500, x_pos=970, y_pos=585 -> collision_det=1, hit_side=1. y_pos=590 (outside 490..589) -> no assertion.
- Left miss: x_pos stepped 12->11->10, held 10 for 50 cycles, y_pos=100 -> exactly one miss_l pulse, score_r=1. Right wall at x_pos=1013 -> miss_r, score_l=1.
- Saturation: 12 left-wall touches -> score_r=9, 12 miss_l pulses.
- Reset mid-operation: reset=0 during HIT -> collision_det=0 and scores 0 on the next edge.

Source files
------------

// File: rtl/ball_collision_det.sv
// ball_collision_det: paddle-contact level for the x motion generator, plus wall misses and scores.
// Define BALL_COLLISION_SCORE_EN to build the wall-miss pulses and score counters.
module ball_collision_det #(
    parameter int BALL_R      = 10,
    parameter int PAD_W       = 10,
    parameter int PAD_H       = 80,
    parameter int LEFT_PAD_X  = 40,
    parameter int RIGHT_PAD_X = 974,
    parameter int SCREEN_W    = 1024,
    parameter int SCORE_MAX   = 9
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    input  logic [11:0] pad_l_y,
    input  logic [11:0] pad_r_y,
    output logic        collision_det,
    output logic        hit_side,
    output logic        miss_l,
    output logic        miss_r,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r
);
    localparam logic [12:0] C_R   = 13'(BALL_R);
    localparam logic [12:0] C_OV  = 13'(PAD_H - 1 + BALL_R);
    localparam logic [12:0] C_LLO = 13'(LEFT_PAD_X + BALL_R);
    localparam logic [12:0] C_LHI = 13'(LEFT_PAD_X + PAD_W - 1 + BALL_R);
    localparam logic [12:0] C_RLO = 13'(RIGHT_PAD_X - BALL_R);
    localparam logic [12:0] C_RHI = 13'(RIGHT_PAD_X + PAD_W - 1 - BALL_R);

    typedef enum logic [1:0] {IDLE, HIT, RELEASE} state_t;

    state_t      r_state, w_next;
    logic [11:0] r_x, r_y, r_pl, r_pr, r_x2, r_x_hit;
    logic        r_hit_l, r_hit_r, r_hit_side;
    logic [12:0] w_x, w_y, w_pl, w_pr;
    logic        w_hit_l, w_hit_r;

    assign w_x  = {1'b0, r_x};
    assign w_y  = {1'b0, r_y};
    assign w_pl = {1'b0, r_pl};
    assign w_pr = {1'b0, r_pr};
    assign w_hit_l = (w_y + C_R >= w_pl) && (w_y <= w_pl + C_OV) && (w_x >= C_LLO) && (w_x <= C_LHI);
    assign w_hit_r = (w_y + C_R >= w_pr) && (w_y <= w_pr + C_OV) && (w_x >= C_RLO) && (w_x <= C_RHI);

    always_ff @(posedge pclk) begin
        if (!reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_pl    <= '0;
            r_pr    <= '0;
            r_x2    <= '0;
            r_hit_l <= 1'b0;
            r_hit_r <= 1'b0;
        end else begin
            r_x     <= x_pos;
            r_y     <= y_pos;
            r_pl    <= pad_l_y;
            r_pr    <= pad_r_y;
            r_x2    <= r_x;
            r_hit_l <= w_hit_l;
            r_hit_r <= w_hit_r;
        end
    end

    // r_x2 is the x that produced the current flags, so the hit latch and release compare share one time base
    always_ff @(posedge pclk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_x_hit    <= '0;
            r_hit_side <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && (r_hit_l || r_hit_r)) begin
                r_x_hit    <= r_x2;
                r_hit_side <= !r_hit_l;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (r_hit_l || r_hit_r) ? HIT : IDLE;
            HIT:     w_next = (r_x2 != r_x_hit) ? RELEASE : HIT;
            RELEASE: w_next = (r_hit_side ? r_hit_r : r_hit_l) ? RELEASE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        collision_det = (r_state == HIT);
        hit_side      = r_hit_side;
    end

`ifdef BALL_COLLISION_SCORE_EN
    logic       r_wall_l, r_wall_r, r_wall_l_q, r_wall_r_q, r_miss_l, r_miss_r;
    logic [3:0] r_score_l, r_score_r;
    logic       w_rise_l, w_rise_r;

    assign w_rise_l = r_wall_l && !r_wall_l_q;
    assign w_rise_r = r_wall_r && !r_wall_r_q;

    always_ff @(posedge pclk) begin
        if (!reset) begin
            r_wall_l   <= 1'b0;
            r_wall_r   <= 1'b0;
            r_wall_l_q <= 1'b0;
            r_wall_r_q <= 1'b0;
            r_miss_l   <= 1'b0;
            r_miss_r   <= 1'b0;
            r_score_l  <= '0;
            r_score_r  <= '0;
        end else begin
            r_wall_l   <= (w_x == C_R);
            r_wall_r   <= (w_x + C_R == 13'(SCREEN_W - 1));
            r_wall_l_q <= r_wall_l;
            r_wall_r_q <= r_wall_r;
            r_miss_l   <= w_rise_l;
            r_miss_r   <= w_rise_r;
            if (w_rise_l && r_score_r != 4'(SCORE_MAX))
                r_score_r <= r_score_r + 4'd1;
            if (w_rise_r && r_score_l != 4'(SCORE_MAX))
                r_score_l <= r_score_l + 4'd1;
        end
    end

    assign miss_l  = r_miss_l;
    assign miss_r  = r_miss_r;
    assign score_l = r_score_l;
    assign score_r = r_score_r;
`else
    assign miss_l  = 1'b0;
    assign miss_r  = 1'b0;
    assign score_l = '0;
    assign score_r = '0;
`endif
endmodule
